mar_burst: RTL

Parametrised memory address register for the CPU datapath. Captures an address from one of several sources (PC, MBR, further channels) into a staging buffer, transfers it to the memory address bus on command, and runs a multi-beat request/acknowledge sequence with auto-increment. This lets one start command drive instruction-fetch bursts or block transfers. It sits between the control unit/datapath sources and the memory port.

---
 rtl/mar_burst.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mar_burst.sv
// rtl/mar_burst.sv - memory address register with staging buffer and multi-beat req/ack bursts
// Optional build macro MAR_LIMIT_CHECK_EN: reject bursts whose last address exceeds ADDR_LIMIT.
module mar_burst #(
    parameter int ADDR_W  = 8,
    parameter int NSRC    = 2,
    parameter int BURST_W = 4,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = {ADDR_W{1'b1}}
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NSRC*ADDR_W-1:0] src_addr,
    input  logic [NSRC-1:0]        src_load,
    input  logic                   start,
    input  logic [BURST_W-1:0]     burst_len,
    input  logic                   mem_ack,
    output logic [ADDR_W-1:0]      addr,
    output logic                   mem_req,
    output logic                   busy,
    output logic                   done,
    output logic                   fault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   buffer;
    logic [BURST_W-1:0]  beats_left;
    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_any;
    logic [BURST_W-1:0]  beats_eff;
    logic                limit_viol;

    // Walk from the highest channel down so the lowest set index wins.
    always_comb begin
        sel_addr = '0;
        sel_any  = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (src_load[i]) begin
                sel_addr = src_addr[i*ADDR_W +: ADDR_W];
                sel_any  = 1'b1;
            end
        end
    end

    assign beats_eff = (burst_len == '0) ? BURST_W'(1) : burst_len;
    assign busy      = (state != S_IDLE);

`ifdef MAR_LIMIT_CHECK_EN
    logic [ADDR_W:0] end_addr;
    logic            fault_q;

    // One extra bit so a burst running past the top of the address space is caught.
    assign end_addr   = {1'b0, buffer} + (ADDR_W+1)'(beats_eff) - (ADDR_W+1)'(1);
    assign limit_viol = (end_addr > {1'b0, ADDR_LIMIT});
    assign fault      = fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (state == S_IDLE && start) begin
            fault_q <= limit_viol;
        end
    end
`else
    logic unused_limit;

    assign unused_limit = ^ADDR_LIMIT;
    assign limit_viol   = 1'b0;
    assign fault        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            buffer     <= '0;
            addr       <= '0;
            beats_left <= '0;
            mem_req    <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (sel_any) begin
                buffer <= sel_addr;
            end
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (limit_viol) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            addr       <= buffer;
                            beats_left <= beats_eff;
                            mem_req    <= 1'b1;
                            state      <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        if (beats_left == BURST_W'(1)) begin
                            mem_req <= 1'b0;
                            done    <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            addr       <= addr + ADDR_W'(1);
                            beats_left <= beats_left - BURST_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
